// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, InvMixColumns sequencer states and GF(2^8) multiply.
// Contents:
//   state_t      128-bit AES state, byte 0 in the MSBs
//   byte_t       one state byte
//   imc_state_e  IDLE / CALC / DONE sequencer states
//   IMC_PRODUCTS number of coefficient x byte products per state
//   gf_mul       GF(2^8) multiply modulo x^8+x^4+x^3+x+1
package aes_pkg;
    typedef logic [127:0] state_t;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} imc_state_e;
    localparam int IMC_PRODUCTS = 64;
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? (p ^ x) : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
endpackage

// File: rtl/inv_mix_columns_cell.sv
// inv_mix_columns_cell: one InvMixColumns product, coefficient(row, term) x column byte.
// Ports:
//   col_in0..col_in3  in  8  the four bytes of one state column
//   row_idx           in  2  output row of the matrix
//   col_idx           in  2  term (which column byte is multiplied)
//   result            out 8  matrix[row_idx][col_idx] * col_in[col_idx]
module inv_mix_columns_cell
    import aes_pkg::*;
(
    input  logic [7:0] col_in0,
    input  logic [7:0] col_in1,
    input  logic [7:0] col_in2,
    input  logic [7:0] col_in3,
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [7:0] result
);
    logic [1:0] k;
    byte_t coef;
    byte_t operand;
    // Matrix row r is {0e,0b,0d,09} rotated right by r, so the entry is picked by (term - row) mod 4.
    assign k = col_idx - row_idx;
    assign coef = k == 2'd0 ? 8'h0e : k == 2'd1 ? 8'h0b : k == 2'd2 ? 8'h0d : 8'h09;
    assign operand = col_idx == 2'd0 ? col_in0 : col_idx == 2'd1 ? col_in1 :
                     col_idx == 2'd2 ? col_in2 : col_in3;
    assign result = gf_mul(coef, operand);
endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: sequences one shared InvMixColumns product cell over a whole AES state.
// Ports:
//   clk        in  1    rising-edge clock
//   rst_n      in  1    asynchronous active-low reset
//   in_valid   in  1    state_in is valid
//   in_ready   out 1    idle and able to accept a state
//   state_in   in  128  input state, byte i = state_in[127-8i -: 8]
//   out_valid  out 1    state_out holds a completed result
//   out_ready  in  1    downstream accepts the result
//   state_out  out 128  InvMixColumns(state_in), same byte ordering
//   busy       out 1    computing or holding a result
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    imc_state_e state;
    imc_state_e state_nx;
    state_t in_reg;
    logic [5:0] cnt;
    logic [31:0] col_word;
    byte_t acc;
    byte_t result;
    byte_t sum;
    logic last_term;
    // cnt = {col, row, term}; the top two bits pick the column being transformed.
    assign col_word = cnt[5:4] == 2'd0 ? in_reg[127:96] : cnt[5:4] == 2'd1 ? in_reg[95:64] :
                      cnt[5:4] == 2'd2 ? in_reg[63:32] : in_reg[31:0];
    assign sum = acc ^ result;
    assign last_term = cnt[1:0] == 2'd3;
    inv_mix_columns_cell u_cell (
        .col_in0 (col_word[31:24]),
        .col_in1 (col_word[23:16]),
        .col_in2 (col_word[15:8]),
        .col_in3 (col_word[7:0]),
        .row_idx (cnt[3:2]),
        .col_idx (cnt[1:0]),
        .result  (result)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CALC;
            CALC:    if (cnt == 6'(IMC_PRODUCTS - 1)) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        in_ready = state == IDLE;
        out_valid = state == DONE;
        busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            in_reg <= '0;
            state_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                in_reg <= state_in;
                cnt <= '0;
                acc <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + 6'd1;
                acc <= last_term ? '0 : sum;
                // Output byte index {col,row} equals cnt[5:2].
                for (int i = 0; i < 16; i++)
                    if (last_term && cnt[5:2] == 4'(i)) state_out[127-8*i -: 8] <= sum;
            end
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: randomized self-checking bench against a column-formula InvMixColumns model.
module tb_inv_mix_columns_seq;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1;
    logic [127:0] state_out;
    logic         busy;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] exp_q[$];
    bit           rand_rdy = 0;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] m9(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction
    function automatic logic [7:0] m11(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction
    function automatic logic [7:0] m13(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction
    function automatic logic [7:0] m14(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction
    function automatic logic [127:0] inv_mc(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
            r[119-32*c -: 8] = m9(a0) ^ m14(a1) ^ m11(a2) ^ m13(a3);
            r[111-32*c -: 8] = m13(a0) ^ m9(a1) ^ m14(a2) ^ m11(a3);
            r[103-32*c -: 8] = m11(a0) ^ m13(a1) ^ m9(a2) ^ m14(a3);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) check("spurious_out_valid", 128'(out_valid), 128'(0));
            else begin
                check("state_out", state_out, exp_q[0]);
                check("in_ready_in_done", 128'(in_ready), 128'(0));
                check("busy_in_done", 128'(busy), 128'(1));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) if (rand_rdy) begin
        #1 out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [127:0] s, output time t_acc);
        int n = 0;
        in_valid = 1;
        state_in = s;
        while (!in_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        t_acc = $time;
        exp_q.push_back(inv_mc(s));
        #1 in_valid = 0;
    endtask

    task automatic wait_valid(output time t_v);
        int n = 0;
        while (!out_valid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) check("valid_timeout", 128'(out_valid), 128'(1));
        t_v = $time;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        time t0, t1, t2;
        logic [127:0] kv, ke, v, prev;
        kv = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
        ke = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
        check("model_known", inv_mc(kv), ke);
        check("model_ff", inv_mc({4{32'hffffffff}}), {4{32'hffffffff}});
        check("model_c6", inv_mc({4{32'hc6c6c6c6}}), {4{32'hc6c6c6c6}});
        check("model_zero", inv_mc(128'd0), 128'd0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_state_out", state_out, 128'd0);
        @(posedge clk);
        #1;

        out_ready = 1;
        send(kv, t0);
        check("busy_calc", 128'(busy), 128'(1));
        wait_valid(t1);
        check("latency", 128'((t1 - t0 - 1) / 10), 128'(64));
        check("known_vector", state_out, ke);
        wait_drain();

        out_ready = 0;
        v = {$urandom, $urandom, $urandom, $urandom};
        send(v, t0);
        wait_valid(t1);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            state_in = kv;
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 128'(in_ready), 128'(1));
        check("bp_release_out_valid", 128'(out_valid), 128'(0));
        check("bp_release_busy", 128'(busy), 128'(0));
        check("state_out_kept", state_out, inv_mc(v));
        check("bp_queue_empty", 128'(exp_q.size()), 128'(0));

        send({4{32'hc6c6c6c6}}, t1);
        send({4{32'h2d26314c}}, t2);
        check("accept_interval", 128'((t2 - t1) / 10), 128'(66));
        wait_valid(t0);
        check("b2b_second", state_out, inv_mc({4{32'h2d26314c}}));
        wait_drain();

        prev = state_out;
        send(kv, t0);
        repeat (30) @(posedge clk);
        #1 rst_n = 0;
        exp_q.delete();
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_state_out", state_out, 128'd0);
        check("midrst_prev_nonzero", 128'(prev != 0), 128'(1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        begin
            bit seen = 0;
            for (int i = 0; i < 70; i++) begin
                @(posedge clk);
                #1;
                seen |= out_valid;
            end
            check("midrst_no_valid", 128'(seen), 128'(0));
        end
        v = {$urandom, $urandom, $urandom, $urandom};
        send(v, t0);
        wait_valid(t1);
        check("after_rst_result", state_out, inv_mc(v));
        wait_drain();

        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            v = i == 0 ? 128'd0 : i == 1 ? {4{32'hffffffff}} : {$urandom, $urandom, $urandom, $urandom};
            send(v, t0);
        end
        wait_drain();
        rand_rdy = 0;
        #1 out_ready = 1;
        check("final_state_out", state_out, inv_mc(v));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
